// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the memory port arbiter slice.
package mem_port_arbiter_pkg;

   // Widths already used by the CPU datapath and the register memory.
   localparam int REGISTER_WIDTH       = 4;
   localparam int MEMORY_ADDRESS_WIDTH = 4;

   // Default arbiter widths track the memory geometry.
   localparam int DEF_DATA_WIDTH = REGISTER_WIDTH;
   localparam int DEF_ADDR_WIDTH = MEMORY_ADDRESS_WIDTH;

   // Ownership phases of the shared memory port.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,  // CPU owns the port
      ST_DRAIN   = 2'd1,  // CPU halting, in-flight access may finish
      ST_PROG    = 2'd2,  // programmer owns the port
      ST_RELEASE = 2'd3   // one-cycle hand-back with CPU restart
   } arb_state_e;

   // True in every phase where the CPU is held off.
   function automatic logic state_is_busy(input arb_state_e s);
      return s != ST_RUN;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs (program pin, UART rx).
module sync_2ff #(
   parameter int          WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Two back-to-back flops give the first stage a full cycle to resolve.
   // NOTE: sequential state uses non-blocking assignments so both stages sample
   // the pre-edge values; blocking here would collapse the chain into one flop.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         meta_q <= RESET_VALUE;
         sync_q <= RESET_VALUE;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single register-memory port between the CPU control unit and
// the UART programmer, halting the CPU for a programming session and
// restarting it from address 0 afterwards.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  p_program_i,
   input  logic                  cpu_idle_i,
   input  logic                  cpu_req_i,
   input  logic                  cpu_we_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_gnt_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   output logic                  cpu_halt_o,
   output logic                  cpu_restart_o,
   input  logic                  prg_req_i,
   input  logic [ADDR_WIDTH-1:0] prg_addr_i,
   input  logic [DATA_WIDTH-1:0] prg_wdata_i,
   output logic                  prg_gnt_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  prog_busy_o,
   output logic [ADDR_WIDTH:0]   prg_count_o,
   output logic                  prg_ovf_o
);

   // Count saturates at the memory depth, one past the last address.
   localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

   arb_state_e            state_q;
   arb_state_e            state_d;
   logic                  p_sync;
   logic                  busy_q;
   logic                  restart_q;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  ovf_q;

   sync_2ff #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_program_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (p_program_i),
      .q_o     (p_sync)
   );

   // Next-state decode and memory port steering; ownership depends on state only.
   // NOTE: every output of this block gets a default first, so no path through
   // the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cpu_gnt_o   = 1'b0;
      prg_gnt_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      unique case (state_q)
         ST_RUN: begin
            cpu_gnt_o = cpu_req_i;
            mem_we_o  = cpu_req_i & cpu_we_i;
            if (p_sync) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // CPU keeps the port so an access already under way can finish.
            cpu_gnt_o = cpu_req_i;
            mem_we_o  = cpu_req_i & cpu_we_i;
            if (cpu_idle_i && !cpu_req_i) state_d = ST_PROG;
         end
         ST_PROG: begin
            mem_addr_o  = prg_addr_i;
            mem_wdata_o = prg_wdata_i;
            prg_gnt_o   = prg_req_i;
            mem_we_o    = prg_req_i;
            // A write in progress holds the session open even after the pin drops.
            if (!p_sync && !prg_req_i) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State register plus flopped control outputs decoded from the next state.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q   <= ST_RUN;
         busy_q    <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= state_is_busy(state_d);
         restart_q <= (state_d == ST_RELEASE);
      end
   end

   // Session write counter: cleared on entry to PROG, saturating, with sticky overflow.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (state_q == ST_DRAIN && state_d == ST_PROG) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (state_q == ST_PROG && prg_req_i) begin
         if (count_q == COUNT_MAX) ovf_q   <= 1'b1;
         else                      count_q <= count_q + COUNT_ONE;
      end
   end

   assign cpu_rdata_o   = mem_rdata_i;
   assign cpu_halt_o    = busy_q;
   assign prog_busy_o   = busy_q;
   assign cpu_restart_o = restart_q;
   assign prg_count_o   = count_q;
   assign prg_ovf_o     = ovf_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 16x4 memory.
module tb_mem_port_arbiter;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       p_program_i;
   logic       cpu_idle_i;
   logic       cpu_req_i;
   logic       cpu_we_i;
   logic [3:0] cpu_addr_i;
   logic [3:0] cpu_wdata_i;
   logic       cpu_gnt_o;
   logic [3:0] cpu_rdata_o;
   logic       cpu_halt_o;
   logic       cpu_restart_o;
   logic       prg_req_i;
   logic [3:0] prg_addr_i;
   logic [3:0] prg_wdata_i;
   logic       prg_gnt_o;
   logic       mem_we_o;
   logic [3:0] mem_addr_o;
   logic [3:0] mem_wdata_o;
   logic [3:0] mem_rdata_i;
   logic       prog_busy_o;
   logic [4:0] prg_count_o;
   logic       prg_ovf_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] mem [16];

   mem_port_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(4)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .p_program_i   (p_program_i),
      .cpu_idle_i    (cpu_idle_i),
      .cpu_req_i     (cpu_req_i),
      .cpu_we_i      (cpu_we_i),
      .cpu_addr_i    (cpu_addr_i),
      .cpu_wdata_i   (cpu_wdata_i),
      .cpu_gnt_o     (cpu_gnt_o),
      .cpu_rdata_o   (cpu_rdata_o),
      .cpu_halt_o    (cpu_halt_o),
      .cpu_restart_o (cpu_restart_o),
      .prg_req_i     (prg_req_i),
      .prg_addr_i    (prg_addr_i),
      .prg_wdata_i   (prg_wdata_i),
      .prg_gnt_o     (prg_gnt_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i),
      .prog_busy_o   (prog_busy_o),
      .prg_count_o   (prg_count_o),
      .prg_ovf_o     (prg_ovf_o)
   );

   always #5 clk_i = ~clk_i;

   // Register memory model: synchronous write, combinational read.
   always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
   assign mem_rdata_i = mem[mem_addr_o];

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      reset_i = 1'b0; p_program_i = 1'b1; cpu_idle_i = 1'b1;
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; prg_req_i = 1'b1;
      cpu_addr_i = 4'h3; cpu_wdata_i = 4'h9; prg_addr_i = 4'h7; prg_wdata_i = 4'h1;
      repeat (5) tick();
      n_checks++; if (cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL rst_halt got=%b exp=0", cpu_halt_o); end
      n_checks++; if (prg_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_prg_gnt got=%b exp=0", prg_gnt_o); end
      n_checks++; if (prg_count_o !== 5'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", prg_count_o); end
      n_checks++; if (cpu_restart_o !== 1'b0) begin n_fail++; $display("FAIL rst_restart got=%b exp=0", cpu_restart_o); end
      n_checks++; if (prog_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", prog_busy_o); end
      p_program_i = 1'b0;
      reset_i = 1'b1;
      #1;
      n_checks++; if (mem_we_o !== 1'b1) begin n_fail++; $display("FAIL run_we got=%b exp=1", mem_we_o); end
      n_checks++; if (mem_addr_o !== 4'h3) begin n_fail++; $display("FAIL run_addr got=%h exp=3", mem_addr_o); end
      n_checks++; if (mem_wdata_o !== 4'h9) begin n_fail++; $display("FAIL run_wdata got=%h exp=9", mem_wdata_o); end
      n_checks++; if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL run_cpu_gnt got=%b exp=1", cpu_gnt_o); end
      n_checks++; if (prg_gnt_o !== 1'b0) begin n_fail++; $display("FAIL run_prg_gnt got=%b exp=0", prg_gnt_o); end
      tick();
      cpu_we_i = 1'b0; prg_req_i = 1'b0;
      #1;
      n_checks++; if (cpu_rdata_o !== 4'h9) begin n_fail++; $display("FAIL run_rdata got=%h exp=9", cpu_rdata_o); end
   endtask

   task automatic test_drain();
      cpu_idle_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b0; prg_req_i = 1'b1;
      p_program_i = 1'b1;
      tick();
      n_checks++; if (cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL drain_halt_e1 got=%b exp=0", cpu_halt_o); end
      tick();
      n_checks++; if (cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL drain_halt_e2 got=%b exp=0", cpu_halt_o); end
      tick();
      n_checks++; if (cpu_halt_o !== 1'b1) begin n_fail++; $display("FAIL drain_halt_e3 got=%b exp=1", cpu_halt_o); end
      n_checks++; if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL drain_cpu_gnt got=%b exp=1", cpu_gnt_o); end
      n_checks++; if (prg_gnt_o !== 1'b0) begin n_fail++; $display("FAIL drain_prg_gnt got=%b exp=0", prg_gnt_o); end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (prog_busy_o !== 1'b1 || cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL drain_hold[%0d] busy=%b gnt=%b exp busy=1 gnt=1", i, prog_busy_o, cpu_gnt_o); end
      end
      // Idle but still requesting: must not leave DRAIN yet.
      cpu_idle_i = 1'b1;
      tick();
      n_checks++; if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL drain_req_hold got=%b exp=1", cpu_gnt_o); end
      cpu_req_i = 1'b0; prg_req_i = 1'b0;
      tick();
      cpu_req_i = 1'b1; prg_req_i = 1'b1;
      #1;
      n_checks++; if (prg_gnt_o !== 1'b1) begin n_fail++; $display("FAIL prog_prg_gnt got=%b exp=1", prg_gnt_o); end
      n_checks++; if (cpu_gnt_o !== 1'b0) begin n_fail++; $display("FAIL prog_cpu_gnt got=%b exp=0", cpu_gnt_o); end
      prg_req_i = 1'b0;
      #1;
      n_checks++; if (prg_gnt_o !== 1'b0 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL prog_idle gnt=%b we=%b exp 0 0", prg_gnt_o, mem_we_o); end
      n_checks++; if (cpu_halt_o !== 1'b1) begin n_fail++; $display("FAIL prog_halt got=%b exp=1", cpu_halt_o); end
   endtask

   task automatic test_prog_writes();
      for (int i = 0; i < 16; i++) begin
         prg_addr_i = 4'(i); prg_wdata_i = 4'(i); prg_req_i = 1'b1;
         #1;
         n_checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 4'(i) || mem_wdata_o !== 4'(i)) begin n_fail++; $display("FAIL wr_port[%0d] we=%b addr=%h data=%h exp 1 %h %h", i, mem_we_o, mem_addr_o, mem_wdata_o, 4'(i), 4'(i)); end
         tick();
         n_checks++; if (prg_count_o !== 5'(i + 1)) begin n_fail++; $display("FAIL wr_count[%0d] got=%0d exp=%0d", i, prg_count_o, i + 1); end
      end
      n_checks++; if (prg_ovf_o !== 1'b0) begin n_fail++; $display("FAIL wr16_ovf got=%b exp=0", prg_ovf_o); end
      prg_addr_i = 4'h0; prg_wdata_i = 4'hF;
      #1;
      n_checks++; if (prg_gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr17_gnt got=%b exp=1", prg_gnt_o); end
      tick();
      n_checks++; if (prg_ovf_o !== 1'b1) begin n_fail++; $display("FAIL wr17_ovf got=%b exp=1", prg_ovf_o); end
      n_checks++; if (prg_count_o !== 5'd16) begin n_fail++; $display("FAIL wr17_count got=%0d exp=16", prg_count_o); end
   endtask

   task automatic test_release();
      // Pin drops while the programmer is still writing: session must stay open.
      prg_addr_i = 4'h1; prg_wdata_i = 4'h1; prg_req_i = 1'b1;
      p_program_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (prog_busy_o !== 1'b1 || cpu_restart_o !== 1'b0 || prg_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rel_hold[%0d] busy=%b rst=%b gnt=%b exp 1 0 1", i, prog_busy_o, cpu_restart_o, prg_gnt_o); end
      end
      prg_req_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b0;
      tick();
      n_checks++; if (cpu_restart_o !== 1'b1 || cpu_halt_o !== 1'b1) begin n_fail++; $display("FAIL rel_pulse rst=%b halt=%b exp 1 1", cpu_restart_o, cpu_halt_o); end
      prg_req_i = 1'b1;
      #1;
      n_checks++; if (cpu_gnt_o !== 1'b0 || prg_gnt_o !== 1'b0 || mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rel_nogrant cpu=%b prg=%b we=%b exp 0 0 0", cpu_gnt_o, prg_gnt_o, mem_we_o); end
      tick();
      prg_req_i = 1'b0;
      n_checks++; if (cpu_restart_o !== 1'b0 || cpu_halt_o !== 1'b0 || prog_busy_o !== 1'b0) begin n_fail++; $display("FAIL rel_run rst=%b halt=%b busy=%b exp 0 0 0", cpu_restart_o, cpu_halt_o, prog_busy_o); end
      cpu_addr_i = 4'h0;
      #1;
      n_checks++; if (cpu_gnt_o !== 1'b1 || cpu_rdata_o !== 4'hF) begin n_fail++; $display("FAIL rd_mem0 gnt=%b data=%h exp 1 f", cpu_gnt_o, cpu_rdata_o); end
      cpu_addr_i = 4'h5;
      #1;
      n_checks++; if (cpu_rdata_o !== 4'h5) begin n_fail++; $display("FAIL rd_mem5 got=%h exp=5", cpu_rdata_o); end
      cpu_addr_i = 4'h3;
      #1;
      n_checks++; if (cpu_rdata_o !== 4'h3) begin n_fail++; $display("FAIL rd_mem3 got=%h exp=3", cpu_rdata_o); end
   endtask

   task automatic test_short_pulse();
      cpu_req_i = 1'b0; cpu_idle_i = 1'b1; prg_req_i = 1'b0;
      tick();
      p_program_i = 1'b1;
      tick();
      p_program_i = 1'b0;
      tick();
      n_checks++; if (cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL pulse_run got=%b exp=0", cpu_halt_o); end
      tick();
      n_checks++; if (cpu_halt_o !== 1'b1 || cpu_restart_o !== 1'b0) begin n_fail++; $display("FAIL pulse_drain halt=%b rst=%b exp 1 0", cpu_halt_o, cpu_restart_o); end
      tick();
      n_checks++; if (cpu_halt_o !== 1'b1 || cpu_restart_o !== 1'b0) begin n_fail++; $display("FAIL pulse_prog halt=%b rst=%b exp 1 0", cpu_halt_o, cpu_restart_o); end
      n_checks++; if (prg_count_o !== 5'd0 || prg_ovf_o !== 1'b0) begin n_fail++; $display("FAIL pulse_clear count=%0d ovf=%b exp 0 0", prg_count_o, prg_ovf_o); end
      tick();
      n_checks++; if (cpu_restart_o !== 1'b1) begin n_fail++; $display("FAIL pulse_release got=%b exp=1", cpu_restart_o); end
      tick();
      n_checks++; if (cpu_halt_o !== 1'b0 || cpu_restart_o !== 1'b0 || prg_count_o !== 5'd0) begin n_fail++; $display("FAIL pulse_end halt=%b rst=%b count=%0d exp 0 0 0", cpu_halt_o, cpu_restart_o, prg_count_o); end
   endtask

   task automatic test_reset_mid_prog();
      p_program_i = 1'b1;
      repeat (4) tick();
      n_checks++; if (prog_busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_enter got=%b exp=1", prog_busy_o); end
      prg_addr_i = 4'h2; prg_wdata_i = 4'h2; prg_req_i = 1'b1;
      tick();
      prg_req_i = 1'b0;
      n_checks++; if (prg_count_o !== 5'd1) begin n_fail++; $display("FAIL mid_count got=%0d exp=1", prg_count_o); end
      #2;
      reset_i = 1'b0;
      #1;
      n_checks++; if (cpu_halt_o !== 1'b0 || prog_busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_async halt=%b busy=%b exp 0 0", cpu_halt_o, prog_busy_o); end
      n_checks++; if (prg_count_o !== 5'd0) begin n_fail++; $display("FAIL mid_count_clr got=%0d exp=0", prg_count_o); end
      p_program_i = 1'b0;
      repeat (2) tick();
      reset_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (cpu_restart_o !== 1'b0 || cpu_halt_o !== 1'b0) begin n_fail++; $display("FAIL mid_norestart[%0d] rst=%b halt=%b exp 0 0", i, cpu_restart_o, cpu_halt_o); end
         tick();
      end
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_drain();
      test_prog_writes();
      test_release();
      test_short_pulse();
      test_reset_mid_prog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single write/read port of the 16x4 register memory between two requesters: the CPU control unit and the UART programmer.
- When program mode is requested, it halts the CPU at the next instruction boundary, then hands the memory port to the programmer for the session.
- When the session ends, it returns the port to the CPU and pulses a restart so the PC reloads address 0.
- Sits between cpu/control_unit, programmer and reg_memory.

Parameters:
- DATA_WIDTH, 4, memory word width.
- ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- p_program_i  in  1  program-mode request pin (asynchronous; synchronized internally)
- cpu_idle_i  in  1  control unit is at an instruction boundary (fetch state)
- cpu_req_i  in  1  CPU memory access request
- cpu_we_i  in  1  CPU write enable
- cpu_addr_i  in  ADDR_WIDTH  CPU address
- cpu_wdata_i  in  DATA_WIDTH  CPU write data
- cpu_gnt_o  out  1  CPU access granted this cycle
- cpu_rdata_o  out  DATA_WIDTH  read data to CPU
- cpu_halt_o  out  1  CPU must stall its FSM
- cpu_restart_o  out  1  one-cycle pulse: CPU reloads PC=0
- prg_req_i  in  1  programmer write request
- prg_addr_i  in  ADDR_WIDTH  programmer address
- prg_wdata_i  in  DATA_WIDTH  programmer write data
- prg_gnt_o  out  1  programmer write granted this cycle
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory combinational read data
- prog_busy_o  out  1  high in DRAIN, PROG, RELEASE
- prg_count_o  out  ADDR_WIDTH+1  writes accepted in current/last session
- prg_ovf_o  out  1  sticky: more than 2**ADDR_WIDTH writes in the session

Behaviour:
- Reset (reset_i=0, async): state=RUN, sync flops=0, prg_count_o=0, prg_ovf_o=0. Registered outputs go to 0 (cpu_halt_o, cpu_restart_o, prog_busy_o). Combinational grants follow the RUN rules.
- p_program_i passes through a 2-flop synchronizer to give p_sync. State changes on the clock edge after the condition is met, so cpu_halt_o rises on the 3rd rising edge after p_program_i goes high.
- RUN:
  - Memory mux selects CPU: cpu_gnt_o = cpu_req_i; mem_we_o = cpu_req_i & cpu_we_i; mem_addr_o / mem_wdata_o come from the CPU.
  - prg_gnt_o=0; programmer requests are ignored, not queued.
  - Go to DRAIN when p_sync=1.
- DRAIN:
  - cpu_halt_o=1, prog_busy_o=1; CPU keeps the port so an in-flight access completes.
  - Go to PROG when cpu_idle_i=1 and cpu_req_i=0 in the same cycle.
  - On PROG entry, clear prg_count_o and prg_ovf_o.
- PROG:
  - cpu_halt_o=1, cpu_gnt_o=0. Mux selects the programmer: prg_gnt_o = prg_req_i; mem_we_o = prg_req_i.
  - Each granted write increments prg_count_o, which saturates at 2**ADDR_WIDTH.
  - A grant while the count is already 2**ADDR_WIDTH sets prg_ovf_o. The write is still performed; addresses wrap mod depth.
  - Go to RELEASE when p_sync=0 and prg_req_i=0. If prg_req_i=1, stay in PROG until the request drops.
  - Minimum residency is 1 cycle, even if p_sync has already fallen.
- RELEASE: lasts one cycle. cpu_halt_o=1, cpu_restart_o=1, no grants, mem_we_o=0. Then go to RUN.
- cpu_rdata_o = mem_rdata_i in every state; it is only meaningful when cpu_gnt_o=1.
- Simultaneous cpu_req_i and prg_req_i: the state alone decides ownership; no cycle ever grants both.
- p_program_i pulse shorter than the DRAIN time: DRAIN is still completed, followed by one PROG cycle, then RELEASE.
- p_program_i re-asserted during RELEASE: go to RUN first, then re-enter DRAIN per the synchronizer latency.
- Reset mid-session: immediate return to RUN, halt released, no restart pulse.

Decomposition:
- Shared package/header holds:
  - state encodings RUN=2'd0, DRAIN=2'd1, PROG=2'd2, RELEASE=2'd3;
  - default widths DATA_WIDTH / ADDR_WIDTH, aligned with the MEMORY_ADDRESS_WIDTH and REGISTER_WIDTH constants already in use.
- One natural sub-module: sync_2ff, a generic 2-flop synchronizer reused for p_program_i and rx_i.

Test Plan:
- Reset low for 5 clocks with all requests active -> cpu_halt_o=0, prg_gnt_o=0, prg_count_o=0. After release, cpu_req_i=1, cpu_we_i=1, addr=4'h3, data=4'h9 -> mem_we_o=1, mem_addr_o=3, cpu_gnt_o=1.
- p_program_i rises while cpu_idle_i=0 for 6 cycles -> cpu_halt_o high by the 3rd edge, state held in DRAIN. Then cpu_idle_i=1 -> PROG next edge; prg_gnt_o follows prg_req_i and cpu_gnt_o=0.
- In PROG, 16 programmer writes addr 0..15 with data = addr -> prg_count_o=16, prg_ovf_o=0. A 17th write -> prg_ovf_o=1, prg_count_o stays 16, memory[0] rewritten.
- Drop p_program_i while prg_req_i=1 -> state stays PROG until prg_req_i=0. Then exactly one cycle of cpu_restart_o=1, followed by RUN with cpu_halt_o=0.
- 1-cycle p_program_i pulse with cpu_idle_i=1 -> DRAIN, one PROG cycle, RELEASE pulse, RUN; prg_count_o=0.
- Assert reset_i=0 mid-PROG -> cpu_halt_o=0 asynchronously, cpu_restart_o never pulses, prg_count_o=0.
